// File: rtl/pulso_mudanca_pkg.sv
// Shared defaults and sizing helpers for the state-change pulse generator.
package pulso_mudanca_pkg;

    localparam int unsigned WIDTH_DEF    = 2;
    localparam int unsigned CHANNELS_DEF = 1;
    localparam int unsigned STRETCH_DEF  = 1;
    localparam int unsigned CNT_W_DEF    = 8;

    // Bits needed to hold the pulse countdown value STRETCH down to 0.
    function automatic int unsigned rest_w(input int unsigned stretch);
        return (stretch < 1) ? 1 : $clog2(stretch + 1);
    endfunction

endpackage

// File: rtl/pulso_mudanca_canal.sv
// One channel: qualified sampling, masked change detection, retriggerable
// pulse stretcher and saturating change counter.
module pulso_canal
    import pulso_mudanca_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned STRETCH = STRETCH_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] estado,
    input  logic             sinal,
    input  logic             sinal15,
    input  logic             caso_esp,
    input  logic [WIDTH-1:0] mascara,
    input  logic             limpa,
    output logic             pulso,
    output logic [WIDTH-1:0] mudou,
    output logic [CNT_W-1:0] contagem
);

    localparam int unsigned RW = rest_w(STRETCH);
    localparam logic [RW-1:0] RELOAD = RW'(STRETCH);

    logic [WIDTH-1:0] ant_q, ant_d;
    logic             armado_q, armado_d;
    logic [RW-1:0]    restante_q, restante_d;
    logic [WIDTH-1:0] mudou_q, mudou_d;
    logic [CNT_W-1:0] cont_q, cont_d;
    logic             pulso_q, pulso_d;

    logic             amostra;
    logic [WIDTH-1:0] dif;
    logic             evento;

    always_comb begin
        ant_d      = ant_q;
        armado_d   = armado_q;
        restante_d = restante_q;
        mudou_d    = mudou_q;
        cont_d     = cont_q;

        amostra = sinal | (sinal15 & caso_esp);
        dif     = (estado ^ ant_q) & mascara;
        evento  = amostra & armado_q & (|dif);

        if (amostra) begin
            ant_d    = estado;
            armado_d = 1'b1;
        end

        // A new event reloads the countdown, so retriggers never open a gap.
        if (evento) begin
            restante_d = RELOAD;
            mudou_d    = dif;
        end else if (restante_q != '0) begin
            restante_d = restante_q - RW'(1);
        end

        if (limpa) begin
            cont_d = '0;
        end else if (evento && (cont_q != {CNT_W{1'b1}})) begin
            cont_d = cont_q + CNT_W'(1);
        end

        pulso_d = (restante_d != '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ant_q      <= '0;
            armado_q   <= 1'b0;
            restante_q <= '0;
            mudou_q    <= '0;
            cont_q     <= '0;
            pulso_q    <= 1'b0;
        end else begin
            ant_q      <= ant_d;
            armado_q   <= armado_d;
            restante_q <= restante_d;
            mudou_q    <= mudou_d;
            cont_q     <= cont_d;
            pulso_q    <= pulso_d;
        end
    end

    assign pulso    = pulso_q;
    assign mudou    = mudou_q;
    assign contagem = cont_q;

endmodule

// File: rtl/pulso_mudanca.sv
// Multi-channel state-change pulse generator; mascara and limpa are shared.
module pulso_mudanca
    import pulso_mudanca_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned CHANNELS = CHANNELS_DEF,
    parameter int unsigned STRETCH  = STRETCH_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] estado,
    input  logic [CHANNELS-1:0]       sinal,
    input  logic [CHANNELS-1:0]       sinal15,
    input  logic [CHANNELS-1:0]       casoEsp,
    input  logic [WIDTH-1:0]          mascara,
    input  logic                      limpa,
    output logic [CHANNELS-1:0]       pulso,
    output logic [CHANNELS*WIDTH-1:0] mudou,
    output logic [CHANNELS*CNT_W-1:0] contagem
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_canal
        pulso_canal #(
            .WIDTH   (WIDTH),
            .STRETCH (STRETCH),
            .CNT_W   (CNT_W)
        ) u_canal (
            .clock    (clock),
            .reset    (reset),
            .estado   (estado[c*WIDTH +: WIDTH]),
            .sinal    (sinal[c]),
            .sinal15  (sinal15[c]),
            .caso_esp (casoEsp[c]),
            .mascara  (mascara),
            .limpa    (limpa),
            .pulso    (pulso[c]),
            .mudou    (mudou[c*WIDTH +: WIDTH]),
            .contagem (contagem[c*CNT_W +: CNT_W])
        );
    end

endmodule
